// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment message scheduler.
// Provides the glyph encodings (bit0=a .. bit6=g), the power-on message
// "GErrY" followed by blanks, and the scheduler state encoding.
package seg_pkg;

  localparam logic [6:0] GLYPH_G     = 7'h3D;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_r     = 7'h50;
  localparam logic [6:0] GLYPH_Y     = 7'h6E;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam int unsigned DEFAULT_MSG_LEN = 8;

  // Index 0 is the first glyph shown.
  localparam logic [DEFAULT_MSG_LEN-1:0][6:0] DEFAULT_MSG = {
    GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_Y,
    GLYPH_r,     GLYPH_r,     GLYPH_E,     GLYPH_G
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Power-on glyph for any message slot; slots past the default text are blank.
  function automatic logic [6:0] default_glyph(input int unsigned idx);
    if (idx < DEFAULT_MSG_LEN) return DEFAULT_MSG[idx[2:0]];
    return GLYPH_BLANK;
  endfunction

endpackage

// File: rtl/seg_tick_prescaler.sv
// Scroll-rate prescaler.
// Ports: clk, rst_n (async active-low); en advances the counter, clr zeroes it
// (clr wins); speed selects how many low counter bits form the tick window;
// tick is high while the low (TICK_DIV_W-speed) bits are all ones, giving a
// period of 2^(TICK_DIV_W-speed) enabled cycles. tick is decoded from the
// current count so a speed change acts immediately without a counter reset.
module seg_tick_prescaler #(
  parameter int unsigned TICK_DIV_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       tick
);

  logic [TICK_DIV_W-1:0] cnt_q;
  logic [TICK_DIV_W-1:0] mask;

  // Bits below TICK_DIV_W-speed take part in the compare; none if speed is too large.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < TICK_DIV_W; i++) begin
      mask[i] = (i + 32'(speed)) < TICK_DIV_W;
    end
  end

  assign tick = &(cnt_q | ~mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TICK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg_msg_scheduler.sv
// Seven-segment message scheduler.
// Steps through a MSG_LEN-entry glyph RAM under run/pause/step/stop control,
// with runtime glyph writes and 3-bit PWM brightness.
// Ports: clk, rst_n (async active-low), ena (global enable/freeze),
// run (level), step/stop (pulses), speed (scroll rate), bright (PWM duty),
// wr_en/wr_addr/wr_glyph (glyph write), segments/dp (registered pin drive),
// busy (not idle), wrap (one-cycle pulse when the pointer returns to 0).
module seg_msg_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV_W = 24,
  parameter int unsigned MSG_LEN    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       run,
  input  logic                       step,
  input  logic                       stop,
  input  logic [2:0]                 speed,
  input  logic [2:0]                 bright,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [6:0]                 wr_glyph,
  output logic [6:0]                 segments,
  output logic                       dp,
  output logic                       busy,
  output logic                       wrap
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [6:0]    ram_q [MSG_LEN];
  logic [2:0]    pwm_q;
  logic          pre_clr, adv, tick, on;

  seg_tick_prescaler #(.TICK_DIV_W(TICK_DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena && (state_q == RUN)),
    .clr   (ena && pre_clr),
    .speed (speed),
    .tick  (tick)
  );

  // Next-state and pointer advance; stop > run > step.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pre_clr = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (!stop && run) begin
          state_d = RUN;
          pre_clr = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          adv = tick;
          if (!run) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (run) begin
          state_d = RUN;
          pre_clr = 1'b1;
        end else begin
          adv = step;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) ptr_d = '0;
    else if (adv)        ptr_d = ptr_q + AW'(1);
  end

  assign on = (pwm_q <= bright);

  // Control state and registered pin drive; ena=0 freezes state and blanks pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      segments <= '0;
      dp       <= 1'b0;
    end else if (!ena) begin
      wrap     <= 1'b0;
      segments <= '0;
      dp       <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy     <= (state_d != IDLE);
      wrap     <= adv && (ptr_q == LAST) && (state_d != IDLE);
      segments <= ((state_q != IDLE) && on) ? ram_q[ptr_q] : 7'd0;
      dp       <= (state_q != IDLE) && on && (ptr_q == LAST);
    end
  end

  // Free-running PWM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pwm_q <= '0;
    else if (ena) pwm_q <= pwm_q + 3'd1;
  end

  // Message RAM; reset reloads the default text.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) ram_q[i] <= default_glyph(i);
    end else if (ena && wr_en) begin
      ram_q[wr_addr] <= wr_glyph;
    end
  end

endmodule

// File: tb/tb_seg_msg_scheduler.sv
// Scoreboard bench for seg_msg_scheduler with a behavioural display model.
module tb_seg_msg_scheduler;

  localparam int unsigned W  = 4;
  localparam int unsigned N  = 8;
  localparam int          NI = 8;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [2:0] bright = 3'd7;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [6:0] wr_glyph = 7'd0;
  logic [6:0] segments;
  logic       dp, busy, wrap;

  seg_msg_scheduler #(.TICK_DIV_W(W), .MSG_LEN(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (run),
    .step     (step),
    .stop     (stop),
    .speed    (speed),
    .bright   (bright),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_glyph (wr_glyph),
    .segments (segments),
    .dp       (dp),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: display mode, glyph index, cycles since scroll start, PWM phase.
  int          m_st, m_ptr, m_pre, m_pwm;
  int          m_ram [NI];
  int          reset_msg [NI] = '{'h3D, 'h79, 'h50, 'h50, 'h6E, 0, 0, 0};
  logic [9:0]  m_out;
  logic [9:0]  exp_q [$];

  task automatic model_reset();
    m_st  = S_IDLE;
    m_ptr = 0;
    m_pre = 0;
    m_pwm = 0;
    m_ram = reset_msg;
    m_out = '0;
  endtask

  task automatic model_step();
    int period, seg, shift;
    bit lit, tick, adv, dpv, wr;
    if (!ena) begin
      m_out = {7'd0, 1'b0, 1'(m_st != S_IDLE), 1'b0};
      return;
    end
    lit   = (m_pwm <= int'(bright));
    seg   = (m_st != S_IDLE && lit) ? m_ram[m_ptr] : 0;
    dpv   = (m_st != S_IDLE) && lit && (m_ptr == NI - 1);
    shift = (int'(speed) < int'(W)) ? int'(W) - int'(speed) : 0;
    period = 1 << shift;
    tick  = (m_st == S_RUN) && ((m_pre % period) == period - 1);
    adv   = 1'b0;
    case (m_st)
      S_IDLE: if (!stop && run) begin m_st = S_RUN; m_pre = 0; end
      S_RUN: begin
        if (stop) begin
          m_st = S_IDLE; m_ptr = 0;
        end else begin
          m_pre = (m_pre + 1) % (1 << W);
          adv = tick;
          if (!run) m_st = S_PAUSE;
        end
      end
      default: begin
        if (stop) begin m_st = S_IDLE; m_ptr = 0; end
        else if (run) begin m_st = S_RUN; m_pre = 0; end
        else adv = step;
      end
    endcase
    wr = 1'b0;
    if (adv) begin
      wr    = (m_ptr == NI - 1);
      m_ptr = (m_ptr + 1) % NI;
    end
    if (wr_en) m_ram[wr_addr] = int'(wr_glyph);
    m_pwm = (m_pwm + 1) % 8;
    m_out = {7'(seg), dpv, 1'(m_st != S_IDLE), wr};
  endtask

  always @(negedge rst_n) model_reset();

  // Stimulus side: the model advances on each edge and queues what the pins must show.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(m_out);
  end

  // Monitor side: every cycle the pins present a value; pop and compare.
  always @(negedge clk) begin : monitor
    logic [9:0] act, expv;
    act = {segments, dp, busy, wrap};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL outs @%0t: no expected entry, actual %h", $time, act);
    end else begin
      expv = exp_q.pop_front();
      if (act !== expv) begin
        n_fail++;
        $display("FAIL outs @%0t: actual seg=%h dp=%b busy=%b wrap=%b, required seg=%h dp=%b busy=%b wrap=%b",
                 $time, act[9:3], act[2], act[1], act[0], expv[9:3], expv[2], expv[1], expv[0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lit_cnt;
    cycles(2);
    check("reset_seg",  int'(segments), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dp",   int'(dp), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1; ena = 1'b1; speed = 3'd0; bright = 3'd7;
    cycles(1);

    // Slowest scroll: one glyph per 16 cycles.
    run = 1'b1;
    cycles(2);  check("run_g0", int'(segments), 'h3D);
    cycles(16); check("run_e1", int'(segments), 'h79);
    cycles(16); check("run_r2", int'(segments), 'h50);

    // Pause on index 2 and overwrite the displayed glyph.
    run = 1'b0;
    cycles(1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_glyph = 7'h7F;
    cycles(1);
    wr_en = 1'b0;
    cycles(1);  check("write_shown", int'(segments), 'h7F);
    cycles(100); check("pause_hold", int'(segments), 'h7F);

    step = 1'b1; cycles(1); step = 1'b0; cycles(1);
    check("step_to3", int'(segments), 'h50);
    step = 1'b1; cycles(1); step = 1'b0; cycles(1);
    check("step_to4", int'(segments), 'h6E);

    // Dim: two lit cycles in every eight.
    bright = 3'd1;
    cycles(2);
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (segments != 7'd0) lit_cnt++;
    end
    check("pwm_duty", lit_cnt, 2);
    bright = 3'd7;
    cycles(2);  check("bright_full", int'(segments), 'h6E);

    // run and step together resume without an extra advance.
    run = 1'b1; step = 1'b1; cycles(1); step = 1'b0; cycles(1);
    check("run_step_noadv", int'(segments), 'h6E);
    check("run_busy", int'(busy), 1);

    // Freeze with ena low.
    cycles(3);
    ena = 1'b0;
    cycles(2);  check("ena_off_seg", int'(segments), 0);
    check("ena_off_busy", int'(busy), 1);
    cycles(48); check("ena_off_hold", int'(segments), 0);
    ena = 1'b1;
    cycles(2);  check("ena_resume", int'(segments), 'h6E);

    // Stop, then restart from index 0.
    stop = 1'b1; run = 1'b0; cycles(1); stop = 1'b0; cycles(1);
    check("stop_busy", int'(busy), 0);
    check("stop_seg", int'(segments), 0);
    run = 1'b1;
    cycles(2);  check("restart_ptr0", int'(segments), 'h3D);

    // Asynchronous reset mid-cycle.
    cycles(5);
    #2 rst_n = 1'b0;
    #1 check("areset_seg", int'(segments), 0);
    check("areset_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;

    // Randomised control, writes and enable drops.
    speed = 3'd4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step  = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 99) == 0) speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) bright = 3'($urandom);
      wr_en    = ($urandom_range(0, 9) == 0);
      wr_addr  = 3'($urandom);
      wr_glyph = 7'($urandom);
      if ($urandom_range(0, 49) == 0) ena = ~ena;
      cycles(1);
    end
    ena = 1'b1; run = 1'b0; step = 1'b0; stop = 1'b0; wr_en = 1'b0;
    speed = 3'd0; bright = 3'd7;
    cycles(2);

    // Reset restores the default message after random writes.
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cycles(1);
    run = 1'b1;
    cycles(2);  check("ram_revert", int'(segments), 'h3D);
    speed = 3'd4;
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
